// File: rtl/byte_word_packer_rx_if.sv
// Byte-in / word-out signal bundle for byte_word_packer_rx.
// master drives the byte stream and ready; slave is the packer.
interface byte_word_packer_rx_if;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        active;
    logic        ready_in;
    logic [31:0] data_out;
    logic [3:0]  byte_en;
    logic        valid_out;
    logic        overflow;
    logic        busy;

    modport master (
        output data_in, valid_in, active, ready_in,
        input  data_out, byte_en, valid_out, overflow, busy
    );

    modport slave (
        input  data_in, valid_in, active, ready_in,
        output data_out, byte_en, valid_out, overflow, busy
    );
endinterface

// File: rtl/byte_word_packer_rx.sv
// Packs 4 valid bytes MSB-first into 32-bit words and buffers them for a valid/ready consumer.
// Optional macro BYTE_PACKER_PARTIAL_FLUSH_EN pushes a partial word when active drops.
//
// state    | meaning
// ---------+--------------------------------------------------
// INACTIVE | receiver not aligned; bytes ignored, count is 0
// ACTIVE   | packing bytes into the word buffer
module byte_word_packer_rx #(
    parameter int FIFO_DEPTH = 2
) (
    input logic                  clk_4f,
    input logic                  reset,
    byte_word_packer_rx_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = AW + 1;

    typedef enum logic {INACTIVE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [1:0]    count_q, count_d;
    logic [31:0]   word_q, word_d;
    logic          push;
    logic [31:0]   push_word;
    logic [3:0]    push_be;

    logic [31:0]   mem_data [FIFO_DEPTH];
    logic [3:0]    mem_be   [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [OW-1:0] occ;
    logic          overflow_q;
    logic          empty, full, pop, do_push;

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q <= INACTIVE;
            count_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            word_q  <= word_d;
        end
    end

    // A byte is taken whenever active is high, including the INACTIVE->ACTIVE cycle.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        word_d    = word_q;
        push      = 1'b0;
        push_word = word_q;
        push_be   = 4'b1111;

        case (state_q)
            INACTIVE: if (bus.active)  state_d = ACTIVE;
            ACTIVE:   if (!bus.active) state_d = INACTIVE;
            default:  state_d = INACTIVE;
        endcase

        if (bus.active && bus.valid_in) begin
            word_d[8*(3 - int'(count_q)) +: 8] = bus.data_in;
            count_d = count_q + 2'd1;
            if (count_q == 2'd3) begin
                push      = 1'b1;
                push_word = word_d;
                word_d    = '0;
            end
        end else if (state_q == ACTIVE && !bus.active) begin
            count_d = '0;
            word_d  = '0;
`ifdef BYTE_PACKER_PARTIAL_FLUSH_EN
            if (count_q != 2'd0) begin
                push      = 1'b1;
                push_word = word_q;
                push_be   = ~(4'b1111 >> count_q);
            end
`endif
        end
    end

    assign empty   = (occ == '0);
    assign full    = (occ == OW'(FIFO_DEPTH));
    assign pop     = !empty && bus.ready_in;
    // A full buffer still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_be[i]   <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_data[wr_ptr] <= push_word;
                mem_be[wr_ptr]   <= push_be;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !pop) begin
                occ <= occ + OW'(1);
            end else if (!do_push && pop) begin
                occ <= occ - OW'(1);
            end
            if (push && !do_push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.valid_out = !empty;
    assign bus.data_out  = empty ? 32'h0 : mem_data[rd_ptr];
    assign bus.byte_en   = empty ? 4'h0  : mem_be[rd_ptr];
    assign bus.overflow  = overflow_q;
    assign bus.busy      = (count_q != 2'd0);
endmodule

// File: tb/tb_byte_word_packer_rx.sv
// Directed-vector bench for byte_word_packer_rx (FIFO_DEPTH=2).
// Honours BYTE_PACKER_PARTIAL_FLUSH_EN for the partial-word expectations.
module tb_byte_word_packer_rx;
    logic clk_4f = 1'b0;
    logic reset  = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    byte_word_packer_rx_if bus();

    byte_word_packer_rx #(.FIFO_DEPTH(2)) dut (
        .clk_4f (clk_4f),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.data_in  = b;
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] word, input logic [3:0] be,
                              input logic vld);
        check_val({tag, "_valid"}, 32'(bus.valid_out), 32'(vld));
        check_val({tag, "_data"},  bus.data_out, word);
        check_val({tag, "_be"},    32'(bus.byte_en), 32'(be));
    endtask

    initial begin
        bus.data_in  = 8'h00;
        bus.valid_in = 1'b0;
        bus.active   = 1'b0;
        bus.ready_in = 1'b0;

        // 1: reset then idle active
        tick();
        tick();
        reset = 1'b0;
        bus.active = 1'b1;
        tick();
        check_head("t1_reset", 32'h0, 4'h0, 1'b0);
        check_val("t1_overflow", 32'(bus.overflow), 32'd0);
        check_val("t1_busy", 32'(bus.busy), 32'd0);

        // 2: one word with ready high
        bus.ready_in = 1'b1;
        send_byte(8'h11);
        send_byte(8'h22);
        check_val("t2_busy_mid", 32'(bus.busy), 32'd1);
        send_byte(8'h33);
        send_byte(8'h44);
        check_head("t2_word", 32'h11223344, 4'hF, 1'b1);
        check_val("t2_busy_done", 32'(bus.busy), 32'd0);
        tick();
        check_head("t2_popped", 32'h0, 4'h0, 1'b0);

        // 3: fill and overflow, then drain
        bus.ready_in = 1'b0;
        for (int i = 1; i <= 12; i++) send_byte(8'(i));
        check_head("t3_full", 32'h01020304, 4'hF, 1'b1);
        check_val("t3_overflow", 32'(bus.overflow), 32'd1);
        tick();
        check_head("t3_stall", 32'h01020304, 4'hF, 1'b1);
        bus.ready_in = 1'b1;
        tick();
        check_head("t3_second", 32'h05060708, 4'hF, 1'b1);
        tick();
        check_head("t3_empty", 32'h0, 4'h0, 1'b0);
        check_val("t3_overflow_sticky", 32'(bus.overflow), 32'd1);

        // 4: gap tolerance
        bus.ready_in = 1'b0;
        send_byte(8'hAA);
        send_byte(8'hBB);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("t4_busy_gap", 32'(bus.busy), 32'd1);
        end
        check_val("t4_no_word_yet", 32'(bus.valid_out), 32'd0);
        send_byte(8'hCC);
        send_byte(8'hDD);
        check_head("t4_word", 32'hAABBCCDD, 4'hF, 1'b1);
        bus.ready_in = 1'b1;
        tick();
        check_head("t4_popped", 32'h0, 4'h0, 1'b0);

        // 5: active drops mid-word
        bus.ready_in = 1'b0;
        send_byte(8'h5A);
        send_byte(8'hA5);
        bus.active = 1'b0;
        tick();
        check_val("t5_busy", 32'(bus.busy), 32'd0);
`ifdef BYTE_PACKER_PARTIAL_FLUSH_EN
        check_head("t5_flush", 32'h5AA50000, 4'b1100, 1'b1);
        bus.ready_in = 1'b1;
        tick();
        bus.ready_in = 1'b0;
`else
        check_head("t5_discard", 32'h0, 4'h0, 1'b0);
`endif
        send_byte(8'hEE);
        check_val("t5_drop_inactive", 32'(bus.busy), 32'd0);
        check_val("t5_nothing_queued", 32'(bus.valid_out), 32'd0);

        // 6: first byte taken on the activating cycle; reset mid-activity
        bus.active = 1'b1;
        send_byte(8'h12);
        check_val("t6_first_byte", 32'(bus.busy), 32'd1);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        send_byte(8'h9A);
        send_byte(8'hBC);
        check_head("t6_pre_reset", 32'h12345678, 4'hF, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_head("t6_reset", 32'h0, 4'h0, 1'b0);
        check_val("t6_busy", 32'(bus.busy), 32'd0);
        check_val("t6_overflow", 32'(bus.overflow), 32'd0);
        send_byte(8'hC0);
        send_byte(8'hDE);
        send_byte(8'hCA);
        send_byte(8'hFE);
        check_head("t6_clean", 32'hC0DECAFE, 4'hF, 1'b1);

        // 7: full + push + pop on one edge
        for (int i = 1; i <= 7; i++) send_byte(8'(i));
        check_val("t7_full_overflow", 32'(bus.overflow), 32'd0);
        bus.ready_in = 1'b1;
        send_byte(8'h08);
        check_head("t7_after_swap", 32'h01020304, 4'hF, 1'b1);
        check_val("t7_no_overflow", 32'(bus.overflow), 32'd0);
        tick();
        check_head("t7_next", 32'h05060708, 4'hF, 1'b1);
        tick();
        check_head("t7_empty", 32'h0, 4'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
